// File: rtl/button_encoder_16x4.sv
// button_encoder_16x4
//   Samples the 16 board button lines, debounces a press, and encodes it into
//   the 4-bit position address used by the one-hot position ROM. The move is
//   offered with a valid/ack handshake, after which the encoder waits for a
//   debounced full release before it will capture another press.
//
// Optional feature macro: BUTTON_ENCODER_SYNC_EN
//   Defined     : botoes passes through a 2-flop synchronizer (+2 cycles).
//   Not defined : botoes is sampled directly (must be synchronous to clock).
//
// Parameters
//   DEBOUNCE_CYCLES : identical samples needed to accept a press or a
//                     release (legal range 2..255).
// Ports
//   clock    in   1 : rising-edge clock
//   reset_n  in   1 : synchronous active-low reset
//   enable   in   1 : allows a new press to be accepted
//   botoes   in  16 : raw button lines, bit i high while button i is pressed
//   ack      in   1 : consumer accepts the presented move
//   address  out  4 : index of the lowest set bit of the accepted pattern
//   valid    out  1 : move presented, held until acknowledged
//   multiple out  1 : accepted pattern had more than one bit set
//   busy     out  1 : encoder is not idle
module button_encoder_16x4 #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] botoes,
  input  logic        ack,
  output logic [3:0]  address,
  output logic        valid,
  output logic        multiple,
  output logic        busy
);

  localparam int unsigned BTN_W = 16;
  localparam int unsigned ADR_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    REPORT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [BTN_W-1:0]   s;
  logic [BTN_W-1:0]   pat;
  logic [BTN_W-1:0]   pat_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [CNT_W:0]     cnt_inc;
  logic               cnt_done;
  logic [ADR_W-1:0]   address_next;
  logic               multiple_next;

  // Input sampling path.
`ifdef BUTTON_ENCODER_SYNC_EN
  logic [BTN_W-1:0] sync_q1;
  logic [BTN_W-1:0] sync_q2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= botoes;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = botoes;
`endif

  // Priority encoder: the descending scan leaves the lowest set index.
  function automatic logic [ADR_W-1:0] lowest_index(input logic [BTN_W-1:0] p);
    logic [ADR_W-1:0] idx;
    idx = '0;
    for (int i = BTN_W - 1; i >= 0; i--) begin
      if (p[i]) idx = ADR_W'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic more_than_one(input logic [BTN_W-1:0] p);
    return (p & (p - BTN_W'(1))) != '0;
  endfunction

  // One extra bit so cnt+1 never wraps before the compare.
  assign cnt_inc  = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign cnt_done = (cnt_inc == (CNT_W + 1)'(DEBOUNCE_CYCLES));

  // Next-state and datapath decode.
  always_comb begin
    state_next    = state;
    pat_next      = pat;
    cnt_next      = cnt;
    address_next  = address;
    multiple_next = multiple;

    case (state)
      IDLE: begin
        if (enable && (s != '0)) begin
          pat_next   = s;
          cnt_next   = CNT_W'(1);
          state_next = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (s == pat) begin
          cnt_next = cnt_inc[CNT_W-1:0];
          if (cnt_done) begin
            state_next    = REPORT;
            address_next  = lowest_index(pat);
            multiple_next = more_than_one(pat);
          end
        end else if (s == '0) begin
          // Bounce back to nothing: drop the candidate.
          state_next = IDLE;
        end else begin
          // Pattern changed while held: restart on the new pattern.
          pat_next = s;
          cnt_next = CNT_W'(1);
        end
      end

      REPORT: begin
        if (ack) begin
          state_next = WAIT_RELEASE;
          cnt_next   = '0;
        end
      end

      WAIT_RELEASE: begin
        if (s == '0) begin
          cnt_next = cnt_inc[CNT_W-1:0];
          if (cnt_done) state_next = IDLE;
        end else begin
          cnt_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      pat      <= '0;
      cnt      <= '0;
      address  <= '0;
      multiple <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      pat      <= pat_next;
      cnt      <= cnt_next;
      address  <= address_next;
      multiple <= multiple_next;
      valid    <= (state_next == REPORT);
      busy     <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_button_encoder_16x4.sv
module tb_button_encoder_16x4;

  localparam int D = 4;
`ifdef BUTTON_ENCODER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = D + SYNC_LAT;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] botoes = 16'hFFFF;
  logic        ack = 1'b0;
  logic [3:0]  address;
  logic        valid;
  logic        multiple;
  logic        busy;

  int tests = 0;
  int fails = 0;

  button_encoder_16x4 #(.DEBOUNCE_CYCLES(D)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .botoes   (botoes),
    .ack      (ack),
    .address  (address),
    .valid    (valid),
    .multiple (multiple),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Behavioural reference: phases of a move, counted in sampled edges.
  localparam int PH_IDLE = 0, PH_DEB = 1, PH_REP = 2, PH_REL = 3;
  int          m_phase = PH_IDLE;
  int          m_cnt = 0;
  logic [15:0] m_pat = 16'h0;
  logic [15:0] m_sy1 = 16'h0, m_sy2 = 16'h0;
  logic [3:0]  m_addr = 4'h0;
  logic        m_mult = 1'b0;

  function automatic logic [3:0] ref_lowest(input logic [15:0] p);
    int k;
    k = 0;
    while (k < 15 && !p[k]) k++;
    return 4'(k);
  endfunction

  always @(posedge clock) begin
    logic [15:0] smp;
`ifdef BUTTON_ENCODER_SYNC_EN
    smp = m_sy2;
`else
    smp = botoes;
`endif
    if (!reset_n) begin
      m_phase = PH_IDLE; m_cnt = 0; m_pat = 16'h0;
      m_addr = 4'h0; m_mult = 1'b0; m_sy1 = 16'h0; m_sy2 = 16'h0;
    end else begin
      m_sy2 = m_sy1;
      m_sy1 = botoes;
      case (m_phase)
        PH_IDLE: if (enable && smp != 16'h0) begin
          m_pat = smp; m_cnt = 1; m_phase = PH_DEB;
        end
        PH_DEB: begin
          if (!enable) m_phase = PH_IDLE;
          else if (smp == m_pat) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == D) begin
              m_phase = PH_REP;
              m_addr  = ref_lowest(m_pat);
              m_mult  = ($countones(m_pat) > 1);
            end
          end else if (smp == 16'h0) m_phase = PH_IDLE;
          else begin
            m_pat = smp; m_cnt = 1;
          end
        end
        PH_REP: if (ack) begin
          m_phase = PH_REL; m_cnt = 0;
        end
        default: begin
          if (smp == 16'h0) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == D) m_phase = PH_IDLE;
          end else m_cnt = 0;
        end
      endcase
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Acknowledge the presented move and let the buttons go fully.
  task automatic finish_move();
    ack = 1'b1; cyc(); ack = 1'b0;
    botoes = 16'h0;
    repeat (LAT + 2) cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; botoes = 16'hFFFF; enable = 1'b1; ack = 1'b0;
    repeat (2) cyc();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (address !== 4'd0) begin fails++; $display("FAIL reset_address: got %0d want 0", address); end
    tests++; if (multiple !== 1'b0) begin fails++; $display("FAIL reset_multiple: got %b want 0", multiple); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    botoes = 16'h0; reset_n = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_clean_press();
    int n, held;
    botoes = 16'h0020; n = 0;
    while (valid !== 1'b1 && n < 50) begin cyc(); n++; end
    tests++; if (n != LAT) begin fails++; $display("FAIL clean_latency: got %0d edges want %0d", n, LAT); end
    tests++; if (address !== 4'd5) begin fails++; $display("FAIL clean_address: got %0d want 5", address); end
    tests++; if (multiple !== 1'b0) begin fails++; $display("FAIL clean_multiple: got %b want 0", multiple); end
    held = 0;
    repeat (10) begin cyc(); if (valid === 1'b1) held++; end
    tests++; if (held != 10) begin fails++; $display("FAIL clean_hold: valid high %0d of 10 cycles", held); end
    ack = 1'b1; cyc(); ack = 1'b0;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL clean_ack: valid got %b want 0", valid); end
    botoes = 16'h0;
    repeat (LAT + 2) cyc();
  endtask

  task automatic test_bounce();
    int n, seen;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      botoes = (i % 2 == 0) ? 16'h0100 : 16'h0000;
      cyc();
      if (valid === 1'b1) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL bounce_novalid: valid seen %0d times want 0", seen); end
    botoes = 16'h0100; n = 0;
    while (valid !== 1'b1 && n < 50) begin cyc(); n++; end
    tests++; if (n != LAT) begin fails++; $display("FAIL bounce_latency: got %0d edges want %0d", n, LAT); end
    tests++; if (address !== 4'd8) begin fails++; $display("FAIL bounce_address: got %0d want 8", address); end
    finish_move();
  endtask

  task automatic test_multi_press();
    int n;
    botoes = 16'h8004; n = 0;
    while (valid !== 1'b1 && n < 50) begin cyc(); n++; end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL multi_valid: got %b want 1", valid); end
    tests++; if (address !== 4'd2) begin fails++; $display("FAIL multi_address: got %0d want 2", address); end
    tests++; if (multiple !== 1'b1) begin fails++; $display("FAIL multi_multiple: got %b want 1", multiple); end
    finish_move();
  endtask

  task automatic test_release_gating();
    int n, busy_cnt, early;
    botoes = 16'h0020; n = 0;
    while (valid !== 1'b1 && n < 50) begin cyc(); n++; end
    ack = 1'b1; cyc(); ack = 1'b0;
    busy_cnt = 0; early = 0;
    repeat (20) begin cyc(); if (busy === 1'b1) busy_cnt++; if (valid === 1'b1) early++; end
    tests++; if (busy_cnt != 20 || early != 0) begin fails++; $display("FAIL release_held: busy %0d/20 valid %0d want 20/0", busy_cnt, early); end
    botoes = 16'h0; n = 0;
    while (busy !== 1'b0 && n < 50) begin cyc(); n++; end
    tests++; if (n != LAT) begin fails++; $display("FAIL release_latency: got %0d edges want %0d", n, LAT); end
    botoes = 16'h0001; n = 0;
    while (valid !== 1'b1 && n < 50) begin cyc(); n++; end
    tests++; if (n != LAT || address !== 4'd0) begin fails++; $display("FAIL release_newpress: got %0d edges addr %0d want %0d/0", n, address, LAT); end
    finish_move();
  endtask

  task automatic test_enable_reset();
    int seen, n;
    botoes = 16'h0040;
    repeat (2 + SYNC_LAT) cyc();
    enable = 1'b0; cyc();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL enable_drop_busy: got %b want 0", busy); end
    seen = 0;
    repeat (D + 3) begin cyc(); if (valid === 1'b1) seen++; end
    tests++; if (seen != 0) begin fails++; $display("FAIL enable_drop_valid: valid seen %0d want 0", seen); end
    enable = 1'b1; n = 0;
    while (valid !== 1'b1 && n < 50) begin cyc(); n++; end
    tests++; if (n != D) begin fails++; $display("FAIL enable_repress: got %0d edges want %0d", n, D); end
    reset_n = 1'b0; cyc();
    tests++; if (valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_in_report: valid %b busy %b want 0 0", valid, busy); end
    reset_n = 1'b1; botoes = 16'h0;
    repeat (LAT + 2) cyc();
  endtask

  task automatic test_random();
    logic [15:0] pick;
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      ack     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0, 1: pick = 16'h0;
          2:    pick = 16'h1 << $urandom_range(0, 15);
          default: pick = 16'($urandom());
        endcase
        botoes = pick;
      end
      cyc();
      tests++;
      if (valid !== (m_phase == PH_REP) || busy !== (m_phase != PH_IDLE)) begin
        fails++;
        $display("FAIL random_ctrl cyc %0d: valid %b busy %b want %b %b", i, valid, busy,
                 m_phase == PH_REP, m_phase != PH_IDLE);
      end
      tests++;
      if (address !== m_addr || multiple !== m_mult) begin
        fails++;
        $display("FAIL random_data cyc %0d: address %0d multiple %b want %0d %b", i, address, multiple, m_addr, m_mult);
      end
    end
    reset_n = 1'b1; enable = 1'b1; ack = 1'b0; botoes = 16'h0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_press();
    test_release_gating();
    test_enable_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_encoder_16x4.md
# button_encoder_16x4

Input-side encoder for the 16-position board: samples the 16 button lines, debounces a press, and encodes it back into the 4-bit position address used by the 16x16 one-hot position ROM, so a player's move can be compared directly against the stored sequence address. It sits between the board buttons and the control unit. A move is presented with a valid/ack handshake. The encoder then waits for full release before it accepts another press.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical nonzero samples required to accept a press, and consecutive all-zero samples required to accept a release. Legal range 2..255.
- `clock`  in  1: single clock. All logic is on the rising edge.
- `reset_n`  in  1: **synchronous, active-low reset**.
- `enable`  in  1: allows a new press to be accepted.
- `botoes`  in  16: raw button lines. Bit i is high while button i is pressed.
- `ack`  in  1: consumer accepts the presented move.
- `address`  out  4: encoded position (index of lowest set bit of the accepted pattern).
- `valid`  out  1: move presented. Held until acknowledged.
- `multiple`  out  1: accepted pattern had more than one bit set. Qualified by `valid`.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- Sample `s` = `botoes` (see Configuration for synchronizer). `pat` = 16-bit capture register. `cnt` = 8-bit counter.
- Reset (`reset_n`=0 at an edge): state←IDLE, `pat`←0, `cnt`←0. `address`=0, `valid`=0, `multiple`=0, `busy`=0. Reset wins over every other condition, in any state.
- **IDLE**:
  - If `enable`=1 and `s`≠0: `pat`←`s`, `cnt`←1, go DEBOUNCE.
  - Otherwise stay in IDLE.
- **DEBOUNCE**:
  - If `enable`=0: go IDLE.
  - Else if `s`==`pat`: `cnt`←`cnt`+1. When `cnt`+1==`DEBOUNCE_CYCLES`, go REPORT, with `address`←lowest set index of `pat` and `multiple`←(popcount(`pat`)>1).
  - Else if `s`==0: go IDLE (bounce, discarded).
  - Else: `pat`←`s`, `cnt`←1, stay in DEBOUNCE (pattern changed, restart).
- **REPORT**:
  - `valid`=1. `address` and `multiple` are stable.
  - `enable` and `s` are ignored.
  - `ack`=1 at an edge: go WAIT_RELEASE, `cnt`←0.
- **WAIT_RELEASE**:
  - `s`==0: `cnt`←`cnt`+1. When `cnt`+1==`DEBOUNCE_CYCLES`, go IDLE.
  - `s`≠0: `cnt`←0 (still held or bouncing).
  - No new press is captured here.
- `address` keeps its last value outside REPORT. It is only meaningful with `valid`=1.
- `busy` = (state≠IDLE), registered with the state.

## Timing
- Edge t is the first edge at which `s` is a stable nonzero pattern.
- Without synchronizer: `valid` is high after edge t+`DEBOUNCE_CYCLES`−1. For D=4 that is edge t+3.
- With synchronizer: `botoes` reaches `s` 2 edges later, so the total latency from raw input is +2 edges.
- `valid` falls on the edge where `ack`=1 is sampled. If `ack` is high when `valid` rises, `valid` lasts exactly one cycle.
- Release: with `s`=0 from edge r onward (first WAIT_RELEASE edge), IDLE is entered after edge r+`DEBOUNCE_CYCLES`−1.
- Simultaneous `ack` and button change in REPORT: only `ack` acts.
- Presses during REPORT or WAIT_RELEASE are never queued.

## Configuration
- `BUTTON_ENCODER_SYNC_EN` defined: `botoes` passes through a 2-flop synchronizer before becoming `s`. Both flops reset to 0 on `reset_n`=0. Latency is +2 cycles.
- Not defined: `s` = `botoes` directly. The inputs must already be synchronous to `clock`.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `botoes`=16'hFFFF → `valid`=0, `address`=0, `multiple`=0, `busy`=0.
- Clean press: D=4, no sync, `botoes`=16'h0020 held, `ack`=0 → `valid` rises after the 4th sampling edge with `address`=5 and `multiple`=0, and stays high for 10 cycles. Pulse `ack` → `valid`=0 the next cycle.
- Bounce: `botoes` toggles 16'h0100/0 every cycle for 6 cycles, then holds 16'h0100 → no `valid` during toggling. `valid` appears 4 edges after the hold begins, with `address`=8.
- Multi-press: `botoes`=16'h8004 held → `valid`=1, `address`=2, `multiple`=1.
- Release gating: after `ack`, keep 16'h0020 held for 20 cycles, then 0 → `busy` stays 1 until 4 zero samples are seen. A new press of 16'h0001 only after that yields `address`=0.
- Enable and reset mid-operation: drop `enable` during DEBOUNCE → IDLE, no `valid`. Assert `reset_n`=0 during REPORT → `valid`=0 and `busy`=0 on the next edge.
